// File: rtl/test_status_dev_if.sv
// Bus interface for the test-status peripheral: a single-cycle request
// strobe with size/direction qualifiers and a registered response strobe.
interface test_status_dev_if;
  logic [31:0] i_bus_data;
  logic [31:0] i_bus_address;
  logic        i_bus_DV;
  logic [2:0]  i_bhw;
  logic        i_write_notread;
  logic [31:0] o_bus_data;
  logic        o_bus_DV;

  modport master (
    output i_bus_data, i_bus_address, i_bus_DV, i_bhw, i_write_notread,
    input  o_bus_data, o_bus_DV
  );

  modport slave (
    input  i_bus_data, i_bus_address, i_bus_DV, i_bhw, i_write_notread,
    output o_bus_data, o_bus_DV
  );
endinterface

// File: rtl/test_status_dev.sv
// Memory-mapped test-result peripheral. Firmware records per-test pass/fail
// results and a DONE marker; a 64-bit cycle counter measures reset-to-DONE.
// Optional watchdog: define TEST_STATUS_WATCHDOG_EN to force DONE and raise
// o_timeout after TIMEOUT_CYCLES cycles without DONE.
module test_status_dev #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_F000,
  parameter logic [63:0] EXPECT_MASK = 64'h0000_1FFF_FFFF_FFFF
`ifdef TEST_STATUS_WATCHDOG_EN
  ,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst,
  test_status_dev_if.slave   bus,
  output logic [63:0]        o_test_pass,
  output logic [63:0]        o_test_fail,
  output logic               o_done,
  output logic               o_all_pass,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    REG_PASS_LO = 3'd0,
    REG_PASS_HI = 3'd1,
    REG_FAIL_LO = 3'd2,
    REG_FAIL_HI = 3'd3,
    REG_RESULT  = 3'd4,
    REG_DONE    = 3'd5,
    REG_CYC_LO  = 3'd6,
    REG_CYC_HI  = 3'd7
  } reg_off_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // State
  logic [63:0] pass_q, pass_d;
  logic [63:0] fail_q, fail_d;
  logic [63:0] cyc_q,  cyc_d;
  logic        done_q, done_d;
  logic        rsp_dv_q, rsp_dv_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        timeout_q;
`ifdef TEST_STATUS_WATCHDOG_EN
  logic        timeout_d;
  logic [31:0] wd_q, wd_d;
`endif

  // Request decode
  logic        req;
  logic        wr;
  reg_off_e    off;
  logic [1:0]  lane;
  size_e       size;
  logic [3:0]  be;
  logic [31:0] bmask;
  logic [31:0] wdata_rep;
  logic        result_pass;
  logic [5:0]  result_idx;
  logic [31:0] rd_word;
  logic [31:0] rd_lane;
  logic [31:0] status_word;

  assign req  = bus.i_bus_DV && (bus.i_bus_address[31:5] == BASE_ADDR[31:5]);
  assign wr   = req && bus.i_write_notread;
  assign off  = reg_off_e'(bus.i_bus_address[4:2]);
  assign lane = bus.i_bus_address[1:0];

  // Word access wins; an empty size field is also treated as a word.
  assign size = (bus.i_bhw[2] || (bus.i_bhw[1:0] == 2'b00)) ? SZ_WORD :
                bus.i_bhw[1] ? SZ_HALF : SZ_BYTE;

  // Sub-word RESULT writes are zero-extended, so bit 31 only counts on words.
  assign result_pass = (size == SZ_WORD) && bus.i_bus_data[31];
  assign result_idx  = bus.i_bus_data[5:0];

`ifdef TEST_STATUS_WATCHDOG_EN
  assign status_word = {30'b0, timeout_q, done_q};
`else
  assign status_word = {31'b0, done_q};
`endif

  // Lane enables and replicated write data for sub-word merges.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    be        = 4'hF;
    wdata_rep = bus.i_bus_data;
    case (size)
      SZ_HALF: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.i_bus_data[15:0]}};
      end
      SZ_BYTE: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{bus.i_bus_data[7:0]}};
      end
      default: ;
    endcase
    bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  // Read mux: select the register word, then extract the addressed lane.
  always_comb begin
    rd_word = 32'd0;
    case (off)
      REG_PASS_LO: rd_word = pass_q[31:0];
      REG_PASS_HI: rd_word = pass_q[63:32];
      REG_FAIL_LO: rd_word = fail_q[31:0];
      REG_FAIL_HI: rd_word = fail_q[63:32];
      REG_RESULT:  rd_word = 32'd0;
      REG_DONE:    rd_word = status_word;
      REG_CYC_LO:  rd_word = cyc_q[31:0];
      REG_CYC_HI:  rd_word = cyc_q[63:32];
      default:     rd_word = 32'd0;
    endcase

    rd_lane = rd_word;
    case (size)
      SZ_HALF: rd_lane = lane[1] ? {16'b0, rd_word[31:16]} : {16'b0, rd_word[15:0]};
      SZ_BYTE: begin
        case (lane)
          2'd0:    rd_lane = {24'b0, rd_word[7:0]};
          2'd1:    rd_lane = {24'b0, rd_word[15:8]};
          2'd2:    rd_lane = {24'b0, rd_word[23:16]};
          default: rd_lane = {24'b0, rd_word[31:24]};
        endcase
      end
      default: ;
    endcase
  end

  // Next-state: register writes, cycle counter, watchdog and response.
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    done_d = done_q;
    cyc_d  = done_q ? cyc_q : cyc_q + 64'd1;

    // Result vectors freeze once DONE is set.
    if (wr && !done_q) begin
      case (off)
        REG_PASS_LO: pass_d[31:0]  = (pass_q[31:0]  & ~bmask) | (wdata_rep & bmask);
        REG_PASS_HI: pass_d[63:32] = (pass_q[63:32] & ~bmask) | (wdata_rep & bmask);
        REG_FAIL_LO: fail_d[31:0]  = (fail_q[31:0]  & ~bmask) | (wdata_rep & bmask);
        REG_FAIL_HI: fail_d[63:32] = (fail_q[63:32] & ~bmask) | (wdata_rep & bmask);
        REG_RESULT: begin
          pass_d[result_idx] = result_pass;
          fail_d[result_idx] = !result_pass;
        end
        default: ;
      endcase
    end

    if (wr && (off == REG_DONE)) done_d = 1'b1;

`ifdef TEST_STATUS_WATCHDOG_EN
    timeout_d = timeout_q;
    wd_d      = wd_q;
    if (!done_q) begin
      wd_d = wd_q + 32'd1;
      if (wd_q == TIMEOUT_CYCLES - 32'd1) begin
        timeout_d = 1'b1;
        done_d    = 1'b1;
      end
    end
`endif

    rsp_dv_d   = req;
    rsp_data_d = (req && !bus.i_write_notread) ? rd_lane : 32'd0;
  end

  // State registers with synchronous reset; reset also drops a pending response.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (i_rst) begin
      pass_q     <= '0;
      fail_q     <= '0;
      cyc_q      <= '0;
      done_q     <= 1'b0;
      rsp_dv_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      cyc_q      <= cyc_d;
      done_q     <= done_d;
      rsp_dv_q   <= rsp_dv_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef TEST_STATUS_WATCHDOG_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign timeout_q = 1'b0;
`endif

  assign bus.o_bus_DV   = rsp_dv_q;
  assign bus.o_bus_data = rsp_data_q;
  assign o_test_pass    = pass_q;
  assign o_test_fail    = fail_q;
  assign o_done         = done_q;
  assign o_timeout      = timeout_q;
  assign o_all_pass     = done_q && !timeout_q && (fail_q == 64'd0) &&
                          ((pass_q & EXPECT_MASK) == EXPECT_MASK);

endmodule

// File: tb/tb_test_status_dev.sv
// Self-checking bench for test_status_dev: a table of directed bus
// transactions plus hand-written sequences for back-to-back traffic,
// DONE freezing, the cycle counter, reset during a request and the watchdog.
module tb_test_status_dev;

  localparam logic [31:0] BASE = 32'h0000_F000;
  localparam logic [63:0] MASK = 64'h0000_1FFF_FFFF_FFFF;
  localparam logic [2:0]  SB = 3'b001, SH = 3'b010, SW = 3'b100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] test_pass, test_fail;
  logic done, all_pass, timeout;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int rel = 0;

  test_status_dev_if bif();

`ifdef TEST_STATUS_WATCHDOG_EN
  test_status_dev #(.BASE_ADDR(BASE), .EXPECT_MASK(MASK), .TIMEOUT_CYCLES(32'd50)) dut (
`else
  test_status_dev #(.BASE_ADDR(BASE), .EXPECT_MASK(MASK)) dut (
`endif
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bif),
    .o_test_pass (test_pass),
    .o_test_fail (test_fail),
    .o_done      (done),
    .o_all_pass  (all_pass),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  bhw;
    logic        exp_dv;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic [31:0] addr, logic [31:0] data,
                              logic [2:0] bhw, logic exp_dv, logic [31:0] exp_data);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.bhw = bhw;
    v.exp_dv = exp_dv; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bif.i_bus_DV        = 1'b0;
    bif.i_write_notread = 1'b0;
    bif.i_bus_address   = 32'd0;
    bif.i_bus_data      = 32'd0;
    bif.i_bhw           = SW;
  endtask

  task automatic drive(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] bhw);
    bif.i_bus_DV        = 1'b1;
    bif.i_write_notread = wr;
    bif.i_bus_address   = addr;
    bif.i_bus_data      = data;
    bif.i_bhw           = bhw;
  endtask

  // Called at a negedge: request is sampled at the next posedge and the
  // response is observed at the following negedge.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] bhw, output logic dv, output logic [31:0] rd);
    drive(wr, addr, data, bhw);
    @(negedge clk);
    dv = bif.o_bus_DV;
    rd = bif.o_bus_data;
    idle();
  endtask

  task automatic req_check(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] bhw,
                           input logic exp_dv, input logic [31:0] exp_data);
    logic dv;
    logic [31:0] rd;
    do_req(wr, addr, data, bhw, dv, rd);
    check({name, "_dv"}, {63'd0, dv}, {63'd0, exp_dv});
    check({name, "_data"}, {32'd0, rd}, {32'd0, exp_data});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    rel = edge_cnt;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_cyc;
    idle();
    apply_reset();

    check("rst_pass", test_pass, 64'd0);
    check("rst_fail", test_fail, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_all_pass", {63'd0, all_pass}, 64'd0);
    check("rst_timeout", {63'd0, timeout}, 64'd0);
    check("rst_bus_dv", {63'd0, bif.o_bus_DV}, 64'd0);

`ifdef TEST_STATUS_WATCHDOG_EN
    // Watchdog: no DONE written, timeout after 50 cycles.
    while (edge_cnt - rel < 49) @(negedge clk);
    check("wd_timeout_before", {63'd0, timeout}, 64'd0);
    check("wd_done_before", {63'd0, done}, 64'd0);
    @(negedge clk);
    check("wd_timeout", {63'd0, timeout}, 64'd1);
    check("wd_done", {63'd0, done}, 64'd1);
    check("wd_all_pass", {63'd0, all_pass}, 64'd0);
    req_check("wd_status", 1'b0, BASE + 32'h14, 32'd0, SW, 1'b1, 32'h3);
    repeat (5) @(negedge clk);
    check("wd_timeout_sticky", {63'd0, timeout}, 64'd1);
`else
    // Directed table. Expected values hand-computed from the register map.
    vecs.push_back(mk(1'b0, BASE + 32'h00, 32'd0, SW, 1'b1, 32'd0));
    vecs.push_back(mk(1'b0, BASE + 32'h04, 32'd0, SW, 1'b1, 32'd0));
    vecs.push_back(mk(1'b0, BASE + 32'h08, 32'd0, SW, 1'b1, 32'd0));
    vecs.push_back(mk(1'b0, BASE + 32'h0C, 32'd0, SW, 1'b1, 32'd0));
    vecs.push_back(mk(1'b0, BASE + 32'h10, 32'd0, SW, 1'b1, 32'd0));
    vecs.push_back(mk(1'b0, BASE + 32'h14, 32'd0, SW, 1'b1, 32'd0));
    // idx 5 pass, idx 5 fail, idx 33 pass
    vecs.push_back(mk(1'b1, BASE + 32'h10, 32'h8000_0005, SW, 1'b1, 32'd0));
    vecs.push_back(mk(1'b1, BASE + 32'h10, 32'h0000_0005, SW, 1'b1, 32'd0));
    vecs.push_back(mk(1'b1, BASE + 32'h10, 32'h8000_0021, SW, 1'b1, 32'd0));
    vecs.push_back(mk(1'b0, BASE + 32'h00, 32'd0, SW, 1'b1, 32'h0000_0000));
    vecs.push_back(mk(1'b0, BASE + 32'h04, 32'd0, SW, 1'b1, 32'h0000_0002));
    vecs.push_back(mk(1'b0, BASE + 32'h08, 32'd0, SW, 1'b1, 32'h0000_0020));
    vecs.push_back(mk(1'b0, BASE + 32'h0C, 32'd0, SW, 1'b1, 32'h0000_0000));
    // sub-word accesses
    vecs.push_back(mk(1'b1, BASE + 32'h01, 32'h0000_00A5, SB, 1'b1, 32'd0));
    vecs.push_back(mk(1'b0, BASE + 32'h00, 32'd0, SW, 1'b1, 32'h0000_A500));
    vecs.push_back(mk(1'b0, BASE + 32'h00, 32'd0, SH, 1'b1, 32'h0000_A500));
    vecs.push_back(mk(1'b0, BASE + 32'h01, 32'd0, SB, 1'b1, 32'h0000_00A5));
    vecs.push_back(mk(1'b0, BASE + 32'h00, 32'd0, SB, 1'b1, 32'h0000_0000));
    vecs.push_back(mk(1'b0, BASE + 32'h02, 32'd0, SH, 1'b1, 32'h0000_0000));
    vecs.push_back(mk(1'b1, BASE + 32'h0A, 32'h0000_1234, SH, 1'b1, 32'd0));
    vecs.push_back(mk(1'b0, BASE + 32'h08, 32'd0, SW, 1'b1, 32'h1234_0020));
    vecs.push_back(mk(1'b0, BASE + 32'h0B, 32'd0, SH, 1'b1, 32'h0000_1234));
    vecs.push_back(mk(1'b0, BASE + 32'h0B, 32'd0, SB, 1'b1, 32'h0000_0012));
    // byte RESULT write: zero-extended, so idx 63 fails
    vecs.push_back(mk(1'b1, BASE + 32'h10, 32'h0000_00FF, SB, 1'b1, 32'd0));
    vecs.push_back(mk(1'b0, BASE + 32'h0C, 32'd0, SW, 1'b1, 32'h8000_0000));
    vecs.push_back(mk(1'b0, BASE + 32'h10, 32'd0, SW, 1'b1, 32'h0000_0000));
    // out-of-window requests produce no response and no effect
    vecs.push_back(mk(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, SW, 1'b0, 32'd0));
    vecs.push_back(mk(1'b0, BASE + 32'h20, 32'd0, SW, 1'b0, 32'd0));
    vecs.push_back(mk(1'b1, 32'h0000_EFE0, 32'hFFFF_FFFF, SW, 1'b0, 32'd0));
    vecs.push_back(mk(1'b0, BASE + 32'h00, 32'd0, SW, 1'b1, 32'h0000_A500));
    // write to read-only counter: acknowledged only
    vecs.push_back(mk(1'b1, BASE + 32'h18, 32'hFFFF_FFFF, SW, 1'b1, 32'd0));

    foreach (vecs[i]) begin
      req_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
                vecs[i].bhw, vecs[i].exp_dv, vecs[i].exp_data);
    end
    check("vec_pass_vector", test_pass, 64'h0000_0002_0000_A500);
    check("vec_fail_vector", test_fail, 64'h8000_0000_1234_0020);

    // Back-to-back reads on three consecutive cycles.
    drive(1'b0, BASE + 32'h04, 32'd0, SW);
    @(negedge clk);
    check("b2b0_dv", {63'd0, bif.o_bus_DV}, 64'd1);
    check("b2b0_data", {32'd0, bif.o_bus_data}, 64'h2);
    drive(1'b0, BASE + 32'h08, 32'd0, SW);
    @(negedge clk);
    check("b2b1_dv", {63'd0, bif.o_bus_DV}, 64'd1);
    check("b2b1_data", {32'd0, bif.o_bus_data}, 64'h1234_0020);
    drive(1'b0, BASE + 32'h00, 32'd0, SW);
    @(negedge clk);
    check("b2b2_dv", {63'd0, bif.o_bus_DV}, 64'd1);
    check("b2b2_data", {32'd0, bif.o_bus_data}, 64'hA500);
    idle();
    @(negedge clk);
    check("b2b_idle_dv", {63'd0, bif.o_bus_DV}, 64'd0);

    // Running cycle counter: read sampled m cycles after reset returns m.
    exp_cyc = 32'(edge_cnt - rel);
    req_check("cyc_lo_running", 1'b0, BASE + 32'h18, 32'd0, SW, 1'b1, exp_cyc);
    req_check("cyc_hi_running", 1'b0, BASE + 32'h1C, 32'd0, SW, 1'b1, 32'd0);

    // Make every expected test pass and clear failures.
    req_check("set_pass_lo", 1'b1, BASE + 32'h00, 32'hFFFF_FFFF, SW, 1'b1, 32'd0);
    req_check("set_pass_hi", 1'b1, BASE + 32'h04, 32'h0000_1FFF, SW, 1'b1, 32'd0);
    req_check("clr_fail_lo", 1'b1, BASE + 32'h08, 32'd0, SW, 1'b1, 32'd0);
    req_check("clr_fail_hi", 1'b1, BASE + 32'h0C, 32'd0, SW, 1'b1, 32'd0);
    check("pre_done_all_pass", {63'd0, all_pass}, 64'd0);
    check("pre_done_pass", test_pass, MASK);

    // DONE write sampled on the 100th cycle after reset.
    check("done_schedule", {63'd0, (edge_cnt - rel) <= 99}, 64'd1);
    while (edge_cnt - rel < 99) @(negedge clk);
    req_check("done_wr", 1'b1, BASE + 32'h14, 32'h1, SW, 1'b1, 32'd0);
    check("done_flag", {63'd0, done}, 64'd1);
    check("done_all_pass", {63'd0, all_pass}, 64'd1);
    req_check("cyc_frozen_a", 1'b0, BASE + 32'h18, 32'd0, SW, 1'b1, 32'd100);
    repeat (7) @(negedge clk);
    req_check("cyc_frozen_b", 1'b0, BASE + 32'h18, 32'd0, SW, 1'b1, 32'd100);
    req_check("cyc_hi_frozen", 1'b0, BASE + 32'h1C, 32'd0, SW, 1'b1, 32'd0);

    // Writes after DONE are acknowledged but ignored.
    req_check("late_result", 1'b1, BASE + 32'h10, 32'h0000_0000, SW, 1'b1, 32'd0);
    req_check("late_pass_lo", 1'b1, BASE + 32'h00, 32'h0000_0000, SW, 1'b1, 32'd0);
    check("late_fail_vector", test_fail, 64'd0);
    check("late_pass_vector", test_pass, MASK);
    check("late_all_pass", {63'd0, all_pass}, 64'd1);
    req_check("done_read", 1'b0, BASE + 32'h14, 32'd0, SW, 1'b1, 32'h1);
    req_check("done_read_byte", 1'b0, BASE + 32'h14, 32'd0, SB, 1'b1, 32'h1);

    // Reset coincident with a request drops the response and clears state.
    drive(1'b0, BASE + 32'h00, 32'd0, SW);
    rst = 1'b1;
    @(negedge clk);
    check("rst_req_dv", {63'd0, bif.o_bus_DV}, 64'd0);
    check("rst_req_data", {32'd0, bif.o_bus_data}, 64'd0);
    check("rst_req_done", {63'd0, done}, 64'd0);
    check("rst_req_pass", test_pass, 64'd0);
    idle();
    @(negedge clk);
    rel = edge_cnt;
    rst = 1'b0;
    req_check("post_rst_pass_lo", 1'b0, BASE + 32'h00, 32'd0, SW, 1'b1, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
